// File: rtl/cr_xp10_decomp_ftr_patch.sv
// XP10 decompressor egress TLV stage: counts DATA payload bytes, patches bytes_out in the
// footer TLV, flags output-limit overruns, and registers everything through a 2-entry skid buffer.
module cr_xp10_decomp_ftr_patch #(
  parameter logic [7:0] DATA_TLV_TYPE  = 8'd9,
  parameter logic [7:0] FTR_TLV_TYPE   = 8'd8,
  parameter logic [3:0] FTR_PATCH_WORD = 4'd12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ib_in_tvalid,
  input  logic        ib_in_tlast,
  input  logic        ib_in_tid,
  input  logic [7:0]  ib_in_tstrb,
  input  logic [7:0]  ib_in_tuser,
  input  logic [63:0] ib_in_tdata,
  output logic        ib_out_tready,
  input  logic        ob_in_tready,
  output logic        ob_out_tvalid,
  output logic        ob_out_tlast,
  output logic        ob_out_tid,
  output logic [7:0]  ob_out_tstrb,
  output logic [7:0]  ob_out_tuser,
  output logic [63:0] ob_out_tdata,
  input  logic [23:0] sw_LZ_DECOMP_OLIMIT,
  output logic        olimit_err,
  output logic        frame_done,
  output logic [31:0] frame_bytes
);

  localparam logic [1:0] ST_HDR   = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_FTR   = 2'd2;
  localparam logic [1:0] ST_OTHER = 2'd3;

  logic [1:0]  state, cur_type, state_nxt;
  logic [3:0]  widx, cur_idx, idx_nxt;
  logic [31:0] cnt, cnt_sum, cnt_next;
  logic [32:0] cnt_wide;
  logic [3:0]  strb_ones;
  logic        olim_hit, in_hs, is_hdr, is_patch, ftr_end, olim_fire;
  logic [63:0] push_data;

  logic [1:0]  occ, occ_nxt;
  logic        pop, load_head, load_e1, head_ftr_end;
  logic        e1_tlast, e1_tid, e1_ftr_end;
  logic [7:0]  e1_tstrb, e1_tuser;
  logic [63:0] e1_tdata;

  // A start flag outside HDR resyncs the parser: the word is treated as a fresh word 0.
  always_comb begin
    in_hs    = ib_in_tvalid & ib_out_tready;
    is_hdr   = (state == ST_HDR) | ib_in_tuser[0];
    cur_idx  = is_hdr ? 4'd0 : widx;
    cur_type = state;
    if (is_hdr) begin
      if (ib_in_tdata[7:0] == DATA_TLV_TYPE)     cur_type = ST_DATA;
      else if (ib_in_tdata[7:0] == FTR_TLV_TYPE) cur_type = ST_FTR;
      else                                       cur_type = ST_OTHER;
    end
    strb_ones = 4'd0;
    for (int i = 0; i < 8; i++) strb_ones = strb_ones + {3'b000, ib_in_tstrb[i]};
    cnt_wide  = {1'b0, cnt} + ((cur_type == ST_DATA && cur_idx != 4'd0) ?
                               {29'd0, strb_ones} : 33'd0);
    cnt_sum   = cnt_wide[32] ? 32'hFFFF_FFFF : cnt_wide[31:0];
    cnt_next  = in_hs ? cnt_sum : cnt;
    is_patch  = (cur_type == ST_FTR) && (cur_idx == FTR_PATCH_WORD);
    ftr_end   = (cur_type == ST_FTR) && ib_in_tuser[1];
    push_data = is_patch ? {ib_in_tdata[63:32], cnt} : ib_in_tdata;
    olim_fire = in_hs && !olim_hit && (sw_LZ_DECOMP_OLIMIT != 24'd0) &&
                (cnt_next > {8'd0, sw_LZ_DECOMP_OLIMIT});
    state_nxt = ib_in_tuser[1] ? ST_HDR : cur_type;
    idx_nxt   = (cur_idx == 4'd15) ? 4'd15 : cur_idx + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_HDR;
      widx        <= 4'd0;
      cnt         <= 32'd0;
      olim_hit    <= 1'b0;
      olimit_err  <= 1'b0;
      frame_bytes <= 32'd0;
    end else begin
      olimit_err <= olim_fire;
      if (in_hs) begin
        state <= state_nxt;
        widx  <= idx_nxt;
        if (ftr_end) begin
          cnt      <= 32'd0;
          olim_hit <= 1'b0;
        end else begin
          cnt <= cnt_next;
          if (olim_fire) olim_hit <= 1'b1;
        end
        if (is_patch) frame_bytes <= cnt;
      end
    end
  end

  // Skid buffer: the ob_out registers are the head entry, e1 holds the second word.
  always_comb begin
    pop       = ob_out_tvalid & ob_in_tready;
    load_head = (pop && occ == 2'd2) || (in_hs && (occ == 2'd0 || pop));
    load_e1   = in_hs && (occ == 2'd1) && !pop;
    occ_nxt   = occ;
    if (in_hs && !pop)      occ_nxt = occ + 2'd1;
    else if (pop && !in_hs) occ_nxt = occ - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ           <= 2'd0;
      ib_out_tready <= 1'b1;
      ob_out_tvalid <= 1'b0;
      ob_out_tlast  <= 1'b0;
      ob_out_tid    <= 1'b0;
      ob_out_tstrb  <= 8'd0;
      ob_out_tuser  <= 8'd0;
      ob_out_tdata  <= 64'd0;
      head_ftr_end  <= 1'b0;
      e1_tlast      <= 1'b0;
      e1_tid        <= 1'b0;
      e1_tstrb      <= 8'd0;
      e1_tuser      <= 8'd0;
      e1_tdata      <= 64'd0;
      e1_ftr_end    <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      occ           <= occ_nxt;
      ib_out_tready <= (occ_nxt != 2'd2);
      ob_out_tvalid <= (occ_nxt != 2'd0);
      frame_done    <= pop & head_ftr_end;
      if (load_head) begin
        if (occ == 2'd2) begin
          ob_out_tlast <= e1_tlast;
          ob_out_tid   <= e1_tid;
          ob_out_tstrb <= e1_tstrb;
          ob_out_tuser <= e1_tuser;
          ob_out_tdata <= e1_tdata;
          head_ftr_end <= e1_ftr_end;
        end else begin
          ob_out_tlast <= ib_in_tlast;
          ob_out_tid   <= ib_in_tid;
          ob_out_tstrb <= ib_in_tstrb;
          ob_out_tuser <= ib_in_tuser;
          ob_out_tdata <= push_data;
          head_ftr_end <= ftr_end;
        end
      end
      if (load_e1) begin
        e1_tlast   <= ib_in_tlast;
        e1_tid     <= ib_in_tid;
        e1_tstrb   <= ib_in_tstrb;
        e1_tuser   <= ib_in_tuser;
        e1_tdata   <= push_data;
        e1_ftr_end <= ftr_end;
      end
    end
  end

endmodule

// File: tb/tb_cr_xp10_decomp_ftr_patch.sv
// Self-checking bench for cr_xp10_decomp_ftr_patch: directed vector table, multi-cycle
// corner sequences and a randomized back-pressure run against a word-level TLV model.
module tb_cr_xp10_decomp_ftr_patch;

  typedef struct packed {
    logic        tlast;
    logic        tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } word_t;

  typedef struct {
    word_t       w;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct {
    word_t       w;
    bit          ftr_end;
    logic [31:0] fb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ib_in_tvalid, ib_in_tlast, ib_in_tid;
  logic [7:0]  ib_in_tstrb, ib_in_tuser;
  logic [63:0] ib_in_tdata;
  logic        ib_out_tready;
  logic        ob_in_tready;
  logic        ob_out_tvalid, ob_out_tlast, ob_out_tid;
  logic [7:0]  ob_out_tstrb, ob_out_tuser;
  logic [63:0] ob_out_tdata;
  logic [23:0] sw_LZ_DECOMP_OLIMIT;
  logic        olimit_err, frame_done;
  logic [31:0] frame_bytes;

  always #5 clk = ~clk;

  cr_xp10_decomp_ftr_patch dut (
    .clk(clk), .rst_n(rst_n),
    .ib_in_tvalid(ib_in_tvalid), .ib_in_tlast(ib_in_tlast), .ib_in_tid(ib_in_tid),
    .ib_in_tstrb(ib_in_tstrb), .ib_in_tuser(ib_in_tuser), .ib_in_tdata(ib_in_tdata),
    .ib_out_tready(ib_out_tready), .ob_in_tready(ob_in_tready),
    .ob_out_tvalid(ob_out_tvalid), .ob_out_tlast(ob_out_tlast), .ob_out_tid(ob_out_tid),
    .ob_out_tstrb(ob_out_tstrb), .ob_out_tuser(ob_out_tuser), .ob_out_tdata(ob_out_tdata),
    .sw_LZ_DECOMP_OLIMIT(sw_LZ_DECOMP_OLIMIT), .olimit_err(olimit_err),
    .frame_done(frame_done), .frame_bytes(frame_bytes)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          occ = 0;
  int          done_cnt = 0;
  int          olim_cnt = 0;
  logic [31:0] last_fb = 32'd0;
  exp_t        exp_q[$];
  word_t       stim_q[$];
  logic [63:0] out_log[$];
  vec_t        tbl[17];

  // Model state: TLV kind (0 hdr, 1 data, 2 ftr, 3 other), word index, byte count.
  int          m_state = 0;
  int          m_idx = 0;
  longint      m_cnt = 0;
  bit          m_olim = 0;
  logic [31:0] m_fb = 32'd0;

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic word_t rand_word();
    word_t w;
    w.tdata = {$urandom, $urandom};
    w.tstrb = 8'($urandom);
    w.tuser = 8'($urandom);
    w.tid   = 1'($urandom);
    w.tlast = 1'($urandom);
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    occ = 0; m_state = 0; m_idx = 0; m_cnt = 0; m_olim = 0; m_fb = 32'd0;
  endtask

  task automatic model_push(input word_t w, output bit olim, output exp_t e);
    bit     hdr;
    int     idx, typ;
    longint nc;
    hdr = (m_state == 0) || w.tuser[0];
    idx = hdr ? 0 : m_idx;
    if (hdr) typ = (w.tdata[7:0] == 8'd9) ? 1 : (w.tdata[7:0] == 8'd8) ? 2 : 3;
    else     typ = m_state;
    e.w = w;
    e.ftr_end = 0;
    if (typ == 2 && idx == 12) begin
      e.w.tdata[31:0] = m_cnt[31:0];
      m_fb = m_cnt[31:0];
    end
    nc = m_cnt;
    if (typ == 1 && idx > 0) nc = nc + $countones(w.tstrb);
    if (nc > 64'hFFFF_FFFF) nc = 64'hFFFF_FFFF;
    olim = 0;
    if (sw_LZ_DECOMP_OLIMIT != 24'd0 && nc > longint'(sw_LZ_DECOMP_OLIMIT) && !m_olim) begin
      olim = 1;
      m_olim = 1;
    end
    m_cnt = nc;
    m_idx = (idx < 15) ? idx + 1 : 15;
    if (w.tuser[1]) begin
      m_state = 0;
      if (typ == 2) begin
        e.ftr_end = 1; m_cnt = 0; m_olim = 0;
      end
    end else begin
      m_state = typ;
    end
    e.fb = m_fb;
  endtask

  // One clock: drive at a falling edge, settle through the rising edge, check at the next fall.
  task automatic applyStimulus(input word_t w, input bit vld, input bit rdy, output bit in_acc);
    bit          out_acc, exp_olim, exp_done;
    logic [31:0] exp_fb;
    exp_t        e, e2;
    ib_in_tvalid = vld;
    ib_in_tlast  = w.tlast;
    ib_in_tid    = w.tid;
    ib_in_tstrb  = w.tstrb;
    ib_in_tuser  = w.tuser;
    ib_in_tdata  = w.tdata;
    ob_in_tready = rdy;
    in_acc   = vld && ib_out_tready;
    out_acc  = ob_out_tvalid && rdy;
    exp_done = 0;
    exp_olim = 0;
    exp_fb   = 32'd0;
    if (out_acc) begin
      out_log.push_back(ob_out_tdata);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out_word", 96'(1), 96'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_word", 96'({ob_out_tlast, ob_out_tid, ob_out_tstrb, ob_out_tuser,
                                     ob_out_tdata}), 96'(e.w));
        exp_done = e.ftr_end;
        exp_fb   = e.fb;
      end
    end
    if (in_acc) begin
      model_push(w, exp_olim, e2);
      exp_q.push_back(e2);
    end
    occ = occ + int'(in_acc) - int'(out_acc);
    @(negedge clk);
    checkOutput("olimit_err", 96'(olimit_err), 96'(exp_olim));
    checkOutput("frame_done", 96'(frame_done), 96'(exp_done));
    if (exp_done) checkOutput("frame_bytes", 96'(frame_bytes), 96'(exp_fb));
    checkOutput("ib_tready", 96'(ib_out_tready), 96'(occ < 2));
    if (olimit_err) olim_cnt++;
    if (frame_done) begin
      done_cnt++;
      last_fb = frame_bytes;
    end
  endtask

  task automatic send_word(input word_t w, input bit rdy);
    bit acc;
    int guard;
    acc = 0;
    guard = 0;
    while (!acc && guard < 20) begin
      applyStimulus(w, 1'b1, rdy, acc);
      guard++;
    end
    if (!acc) checkOutput("send_timeout", 96'(0), 96'(1));
  endtask

  task automatic add_tlv(input logic [7:0] typ, input int n, input bit full, input bit drop_end);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.tdata = {$urandom, $urandom};
      w.tstrb = full ? 8'hFF : 8'($urandom);
      w.tuser = {6'($urandom), 2'b00};
      w.tid   = 1'($urandom);
      if (i == 0) begin
        w.tdata[7:0] = typ;
        w.tuser[0]   = 1'b1;
      end
      if (i == n - 1 && !drop_end) w.tuser[1] = 1'b1;
      w.tlast = (i == n - 1) && (typ == 8'd8);
      stim_q.push_back(w);
    end
  endtask

  task automatic run_queue(input int vld_pct, input int rdy_pct);
    bit acc, v, r;
    int guard;
    guard = 0;
    while (stim_q.size() > 0 && guard < 5000) begin
      v = ($urandom_range(0, 99) < 32'(vld_pct));
      r = ($urandom_range(0, 99) < 32'(rdy_pct));
      applyStimulus(v ? stim_q[0] : rand_word(), v, r, acc);
      if (acc) void'(stim_q.pop_front());
      guard++;
    end
    if (stim_q.size() > 0) begin
      checkOutput("stim_timeout", 96'(stim_q.size()), 96'(0));
      stim_q.delete();
    end
    guard = 0;
    while (occ > 0 && guard < 100) begin
      applyStimulus(rand_word(), 1'b0, 1'b1, acc);
      guard++;
    end
    if (occ > 0) checkOutput("drain_timeout", 96'(occ), 96'(0));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    word_t w;
    bit    acc;
    int    r, n;

    rst_n = 1'b0;
    ib_in_tvalid = 1'b0; ib_in_tlast = 1'b0; ib_in_tid = 1'b0;
    ib_in_tstrb = 8'd0; ib_in_tuser = 8'd0; ib_in_tdata = 64'd0;
    ob_in_tready = 1'b0;
    sw_LZ_DECOMP_OLIMIT = 24'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_ob_tvalid", 96'(ob_out_tvalid), 96'(0));
    checkOutput("rst_ob_tdata", 96'(ob_out_tdata), 96'(0));
    checkOutput("rst_ib_tready", 96'(ib_out_tready), 96'(1));
    checkOutput("rst_olimit_err", 96'(olimit_err), 96'(0));
    checkOutput("rst_frame_done", 96'(frame_done), 96'(0));
    checkOutput("rst_frame_bytes", 96'(frame_bytes), 96'(0));

    // Vector table: DATA of FF/FF/0F payload, then a 13-word FTR whose word 12 carries DEADBEEF.
    for (int i = 0; i < 17; i++) begin
      tbl[i].w.tlast = 1'b0;
      tbl[i].w.tid   = 1'b0;
      tbl[i].w.tstrb = 8'hFF;
      tbl[i].w.tuser = 8'h00;
      tbl[i].w.tdata = {32'hA5A5_0000 + 32'(i), 32'h1234_5600 + 32'(i)};
    end
    tbl[0].w.tuser = 8'h01;  tbl[0].w.tdata[7:0] = 8'd9;
    tbl[3].w.tstrb = 8'h0F;  tbl[3].w.tuser = 8'h02;
    tbl[4].w.tuser = 8'h01;  tbl[4].w.tdata[7:0] = 8'd8;
    tbl[16].w.tuser = 8'h02; tbl[16].w.tlast = 1'b1;
    tbl[16].w.tdata = 64'hCAFE_F00D_DEAD_BEEF;
    for (int i = 0; i < 17; i++) tbl[i].exp_data = tbl[i].w.tdata;
    tbl[16].exp_data = 64'hCAFE_F00D_0000_0014;

    out_log.delete();
    done_cnt = 0;
    for (int i = 0; i < 17; i++) send_word(tbl[i].w, 1'b1);
    run_queue(100, 100);
    if (out_log.size() < 17) checkOutput("tbl_out_count", 96'(out_log.size()), 96'(17));
    for (int i = 0; i < 17 && i < out_log.size(); i++)
      checkOutput("tbl_data", 96'(out_log[i]), 96'(tbl[i].exp_data));
    checkOutput("tbl_done_pulses", 96'(done_cnt), 96'(1));
    checkOutput("tbl_frame_bytes", 96'(last_fb), 96'(20));

    // Next frame must count from zero.
    add_tlv(8'd9, 2, 1'b1, 1'b0);
    add_tlv(8'd8, 13, 1'b1, 1'b0);
    run_queue(100, 100);
    checkOutput("next_frame_bytes", 96'(last_fb), 96'(8));

    // Output limit: 24 bytes against a limit of 16, then the same frame with no limit.
    sw_LZ_DECOMP_OLIMIT = 24'd16;
    olim_cnt = 0;
    add_tlv(8'd9, 4, 1'b1, 1'b0);
    add_tlv(8'd8, 3, 1'b1, 1'b0);
    run_queue(100, 100);
    checkOutput("olim_pulses_16", 96'(olim_cnt), 96'(1));
    sw_LZ_DECOMP_OLIMIT = 24'd0;
    olim_cnt = 0;
    add_tlv(8'd9, 4, 1'b1, 1'b0);
    add_tlv(8'd8, 3, 1'b1, 1'b0);
    run_queue(100, 100);
    checkOutput("olim_pulses_0", 96'(olim_cnt), 96'(0));

    // OTHER TLVs between DATA TLVs do not disturb the count.
    add_tlv(8'd9, 2, 1'b1, 1'b0);
    add_tlv(8'd7, 5, 1'b1, 1'b0);
    add_tlv(8'd9, 2, 1'b1, 1'b0);
    add_tlv(8'd8, 13, 1'b1, 1'b0);
    run_queue(100, 100);
    checkOutput("interleave_bytes", 96'(last_fb), 96'(16));

    // Saturation: preload the counter near its ceiling during an idle cycle.
    add_tlv(8'd9, 1, 1'b1, 1'b1);
    w = stim_q.pop_front();
    send_word(w, 1'b1);
    force dut.cnt = 32'hFFFF_FFFA;
    applyStimulus(rand_word(), 1'b0, 1'b1, acc);
    release dut.cnt;
    m_cnt = 64'hFFFF_FFFA;
    w = rand_word();
    w.tuser = 8'h02;
    w.tstrb = 8'hFF;
    send_word(w, 1'b1);
    checkOutput("cnt_saturated", 96'(dut.cnt), 96'(32'hFFFF_FFFF));
    add_tlv(8'd8, 13, 1'b1, 1'b0);
    run_queue(100, 100);
    checkOutput("sat_frame_bytes", 96'(last_fb), 96'(32'hFFFF_FFFF));

    // Reset in the middle of a DATA TLV with one word still buffered.
    add_tlv(8'd9, 4, 1'b1, 1'b0);
    w = stim_q.pop_front();
    send_word(w, 1'b0);
    w = stim_q.pop_front();
    send_word(w, 1'b1);
    stim_q.delete();
    rst_n = 1'b0;
    ib_in_tvalid = 1'b0;
    ob_in_tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checkOutput("midrst_ob_tvalid", 96'(ob_out_tvalid), 96'(0));
    checkOutput("midrst_ib_tready", 96'(ib_out_tready), 96'(1));
    checkOutput("midrst_frame_bytes", 96'(frame_bytes), 96'(0));
    add_tlv(8'd9, 3, 1'b1, 1'b0);
    add_tlv(8'd8, 13, 1'b1, 1'b0);
    run_queue(100, 100);
    checkOutput("midrst_next_bytes", 96'(last_fb), 96'(16));

    // Random TLV mix under 50% downstream back-pressure.
    sw_LZ_DECOMP_OLIMIT = ($urandom_range(0, 1) != 0) ? 24'($urandom_range(1, 200)) : 24'd0;
    while (stim_q.size() < 200) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0, 3: add_tlv(8'd9, int'($urandom_range(1, 8)), 1'b0, ($urandom_range(0, 9) == 0));
        1:    add_tlv(8'd5, int'($urandom_range(1, 6)), 1'b0, ($urandom_range(0, 9) == 0));
        default: begin
          n = int'($urandom_range(0, 4));
          n = (n == 0) ? 3 : (n == 1) ? 13 : (n == 2) ? 14 : (n == 3) ? 20 : 30;
          add_tlv(8'd8, n, 1'b0, ($urandom_range(0, 9) == 0));
        end
      endcase
    end
    add_tlv(8'd8, 13, 1'b0, 1'b0);
    run_queue(80, 50);
    checkOutput("rand_leftover", 96'(exp_q.size()), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
